// File: rtl/upower_ctrl_pkg.sv
// Shared opcode, XO, BO and ALU encodings, FSM states and the registered control bundle
// for the uPOWER multi-cycle controller.
package upower_ctrl_pkg;

  localparam logic [5:0] OP_ADDI = 6'd14;
  localparam logic [5:0] OP_BC   = 6'd16;
  localparam logic [5:0] OP_ORI  = 6'd24;
  localparam logic [5:0] OP_ANDI = 6'd28;
  localparam logic [5:0] OP_XO   = 6'd31;
  localparam logic [5:0] OP_LD   = 6'd58;
  localparam logic [5:0] OP_STD  = 6'd62;

  localparam logic [9:0] XO_AND = 10'd28;
  localparam logic [9:0] XO_ADD = 10'd266;
  localparam logic [9:0] XO_OR  = 10'd444;

  localparam logic [4:0] BO_BEQ = 5'b01100;
  localparam logic [4:0] BO_BNE = 5'b00100;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic       reg1;
    logic       reg2;
    logic       mem_to_reg;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/upower_mc_controller_if.sv
// Controller <-> datapath/memory signal bundle; master = controller, slave = datapath side.
interface upower_mc_controller_if #(
  parameter int CNT_W = 32
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             mem_ready;
  logic             zero_flag;
  logic [31:0]      ir_out;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             ALUSrc;
  logic             RegDst;
  logic             reg1;
  logic             reg2;
  logic [3:0]       ALU_OP;
  logic             pc_en;
  logic             pc_src;
  logic             illegal;
  logic             mem_err;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  instr_valid, instr, mem_ready, zero_flag,
    output ir_out, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst,
           reg1, reg2, ALU_OP, pc_en, pc_src, illegal, mem_err, retired_count
  );

  modport slave (
    output instr_valid, instr, mem_ready, zero_flag,
    input  ir_out, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst,
           reg1, reg2, ALU_OP, pc_en, pc_src, illegal, mem_err, retired_count
  );
endinterface

// File: rtl/upower_ctrl_decoder.sv
// Combinational instruction decoder: ir -> control bundle plus class flags and legality.
module upower_ctrl_decoder
  import upower_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        branch_ne,
  output logic        legal
);

  // Register-number fields are consumed by the datapath, not by decode.
  logic unused_ir;
  assign unused_ir = ^ir[20:11];

  always_comb begin
    ctrl      = '0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    legal     = 1'b0;
    case (ir[31:26])
      OP_LD: if (ir[1:0] == 2'b00) begin
        legal = 1'b1; is_load = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.reg1 = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_STD: if (ir[1:0] == 2'b00) begin
        legal = 1'b1; is_store = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.reg1 = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_ADDI: begin
        legal = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg1 = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_ANDI: begin
        legal = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_AND;
      end
      OP_ORI: begin
        legal = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_OR;
      end
      OP_XO: begin
        ctrl.reg2 = 1'b1;
        case (ir[10:1])
          XO_ADD: begin legal = 1'b1; ctrl.reg1 = 1'b1; ctrl.alu_op = ALU_ADD; end
          XO_AND: begin legal = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_AND; end
          XO_OR:  begin legal = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_OR; end
          default: ;
        endcase
      end
      OP_BC: begin
        is_branch = 1'b1;
        ctrl.reg1 = 1'b1; ctrl.reg2 = 1'b1; ctrl.alu_op = ALU_SUB;
        if (ir[25:21] == BO_BEQ) begin
          legal = 1'b1;
        end else if (ir[25:21] == BO_BNE) begin
          legal = 1'b1; branch_ne = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/upower_mc_controller.sv
// uPOWER multi-cycle sequencer FETCH/DECODE/EXEC/MEM/WB with memory wait/timeout and sticky traps.
// Retired-instruction counter is built only when UPOWER_PERF_CNT_EN is defined.
module upower_mc_controller
  import upower_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  upower_mc_controller_if.master bus
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  ctrl_t       ctrl_q, dec_ctrl;
  logic        ld_q, st_q, br_q, bne_q;
  logic        dec_ld, dec_st, dec_br, dec_bne, dec_legal;
  logic        illegal_q, mem_err_q;
  logic [7:0]  to_q;

  logic reg_write, mem_read, mem_write, pc_en, pc_src;
  logic capture, dec_load, set_ill, set_merr, to_clr, to_inc;

  upower_ctrl_decoder u_dec (
    .ir        (ir_q),
    .ctrl      (dec_ctrl),
    .is_load   (dec_ld),
    .is_store  (dec_st),
    .is_branch (dec_br),
    .branch_ne (dec_bne),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 1'b0;
    capture   = 1'b0;
    dec_load  = 1'b0;
    set_ill   = 1'b0;
    set_merr  = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    case (state_q)
      FETCH: if (bus.instr_valid) begin
        capture = 1'b1;
        state_d = DECODE;
      end
      DECODE: if (dec_legal) begin
        dec_load = 1'b1;
        state_d  = EXEC;
      end else begin
        set_ill = 1'b1;
        state_d = TRAP;
      end
      EXEC: if (br_q) begin
        pc_en   = 1'b1;
        pc_src  = bus.zero_flag ^ bne_q;
        state_d = FETCH;
      end else if (ld_q || st_q) begin
        to_clr  = 1'b1;
        state_d = MEM;
      end else begin
        state_d = WB;
      end
      MEM: begin
        mem_read  = ld_q;
        mem_write = st_q;
        // Ready in the limit cycle still completes the access.
        if (bus.mem_ready) begin
          if (ld_q) begin
            state_d = WB;
          end else begin
            pc_en   = 1'b1;
            state_d = FETCH;
          end
        end else if (to_q == TO_LAST) begin
          set_merr = 1'b1;
          state_d  = TRAP;
        end else begin
          to_inc = 1'b1;
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        state_d   = FETCH;
      end
      TRAP: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q      <= '0;
      ctrl_q    <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      br_q      <= 1'b0;
      bne_q     <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      to_q      <= '0;
    end else begin
      if (capture) ir_q <= bus.instr;
      if (dec_load) begin
        ctrl_q <= dec_ctrl;
        ld_q   <= dec_ld;
        st_q   <= dec_st;
        br_q   <= dec_br;
        bne_q  <= dec_bne;
      end
      if (set_ill)  illegal_q <= 1'b1;
      if (set_merr) mem_err_q <= 1'b1;
      if (to_clr)      to_q <= '0;
      else if (to_inc) to_q <= to_q + 8'd1;
    end
  end

`ifdef UPOWER_PERF_CNT_EN
  logic [CNT_W-1:0] perf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       perf_q <= '0;
    else if (pc_en) perf_q <= perf_q + 1'b1;
  end
  assign bus.retired_count = perf_q;
`else
  assign bus.retired_count = {CNT_W{1'b0}};
`endif

  assign bus.ir_out   = ir_q;
  assign bus.RegWrite = reg_write;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.pc_en    = pc_en;
  assign bus.pc_src   = pc_src;
  assign bus.MemtoReg = ctrl_q.mem_to_reg;
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.RegDst   = ctrl_q.reg_dst;
  assign bus.reg1     = ctrl_q.reg1;
  assign bus.reg2     = ctrl_q.reg2;
  assign bus.ALU_OP   = ctrl_q.alu_op;
  assign bus.illegal  = illegal_q;
  assign bus.mem_err  = mem_err_q;

endmodule

// File: doc/upower_mc_controller.md
Name: upower_mc_controller

Overview:
- Multi-cycle control sequencer for the uPOWER load/store/R/I datapath.
- Latches each fetched instruction and decodes it.
- Steps the instruction through FETCH/DECODE/EXEC/MEM/WB, driving the datapath control inputs (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, reg1, reg2, ALU_OP).
- Advances the PC via pc_en/pc_src and handles data-memory wait states.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM-state cycles without mem_ready before mem_err (valid range 1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
instr_valid  input  1  instr holds a valid fetched word this cycle
instr  input  32  fetched instruction word
mem_ready  input  1  data memory completed access this cycle
zero_flag  input  1  ALU zero output from datapath
ir_out  output  32  latched instruction driven to datapath
RegWrite  output  1  register file write enable
MemRead  output  1  data memory read enable
MemWrite  output  1  data memory write enable
MemtoReg  output  1  1 = writeback from memory, 0 = from ALU
ALUSrc  output  1  1 = immediate operand, 0 = register
RegDst  output  1  1 = write instr[20:16], 0 = instr[25:21]
reg1  output  1  1 = read1 from instr[20:16], 0 = from instr[25:21]
reg2  output  1  1 = read2 from instr[15:11], 0 = from instr[25:21]
ALU_OP  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
pc_en  output  1  one-cycle PC update pulse
pc_src  output  1  with pc_en: 1 = branch target, 0 = PC+4
illegal  output  1  sticky: unsupported opcode trapped
mem_err  output  1  sticky: memory timeout trapped
retired_count  output  CNT_W  retired instructions (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - State → FETCH.
  - All outputs, ir_out and the timeout counter → 0.
  - Reset mid-instruction aborts it; no partial RegWrite or MemWrite after rst asserts.
- FETCH: wait for instr_valid; on it, ir_out <= instr, go to DECODE.
- DECODE: decode ir_out and register the control bundle (ALUSrc, RegDst, reg1, reg2, ALU_OP, MemtoReg), held stable until the next FETCH. Illegal opcode → TRAP.
- Decode table (opcode = ir[31:26]):
  - ld, 58, ir[1:0]=00: ALUSrc=1, RegDst=0, reg1=1, MemtoReg=1, ADD
  - std, 62, ir[1:0]=00: ALUSrc=1, reg1=1, reg2=0, ADD, no writeback
  - addi, 14: ALUSrc=1, RegDst=0, reg1=1, ADD
  - andi, 28: ALUSrc=1, RegDst=1, reg1=0, AND
  - ori, 24: ALUSrc=1, RegDst=1, reg1=0, OR
  - opcode 31, XO = ir[10:1]; all use ALUSrc=0, reg2=1:
    - add, 266: RegDst=0, reg1=1, ADD
    - and, 28: RegDst=1, reg1=0, AND
    - or, 444: RegDst=1, reg1=0, OR
  - beq/bne, 16: ALUSrc=0, reg1=1, reg2=1, SUB. ir[25:21]=01100 → beq, 00100 → bne; any other BO is illegal.
- EXEC: one cycle, ALU settles.
  - Branch: pc_en=1; pc_src = zero_flag (beq) or ~zero_flag (bne); → FETCH.
  - ld/std → MEM; ALU ops → WB.
- MEM:
  - MemRead (ld) or MemWrite (std) held high until the cycle mem_ready=1.
  - ld → WB.
  - std: pc_en=1 in the mem_ready cycle, then → FETCH.
  - Timeout counter clears on MEM entry and increments each cycle without mem_ready. On reaching MEM_TIMEOUT: drop MemRead/MemWrite, set mem_err, → TRAP.
  - mem_ready in the same cycle the limit is reached: ready wins, no error.
- WB: RegWrite=1 for exactly one cycle, pc_en=1 (pc_src=0) in the same cycle, → FETCH.
- Latency (mem_ready immediate):
  - ALU op: 4 cycles
  - ld: 5 cycles
  - std: 4 cycles
  - branch: 3 cycles
  - Each extra MEM wait adds one cycle.
- TRAP:
  - RegWrite, MemRead, MemWrite, pc_en = 0.
  - illegal/mem_err held; only reset exits.
- instr_valid is ignored outside FETCH.
- pc_en never asserts twice for one instruction.

Optional Feature:
- Macro: UPOWER_PERF_CNT_EN.
- Defined:
  - retired_count increments by 1 on every pc_en pulse.
  - Wraps at 2^CNT_W-1 → 0.
  - Reset to 0.
- Undefined: retired_count is tied to 0 and no counter flops are built.

Decomposition:
- Package upower_ctrl_pkg holds:
  - Primary opcodes (14, 16, 24, 28, 31, 58, 62) and XO values (28, 266, 444).
  - BO codes (01100, 00100).
  - ALU_OP encodings (0000, 0001, 0010, 0110).
  - State enum: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - Control-bundle struct.
- Sub-module upower_ctrl_decoder: purely combinational, ir[31:0] → control bundle, is_load, is_store, is_branch, branch_ne, legal.
- The FSM, timeout counter and perf counter stay in upower_mc_controller.

Test Plan:
1. Reset released, instr_valid=1, instr=32'h3A200014 (addi R17,R0,20) → DECODE: ALUSrc=1, RegDst=0, reg1=1, ALU_OP=0010; RegWrite and pc_en pulse together 4 cycles after FETCH capture; pc_src=0.
2. instr=32'hE8220004 (ld R1,1(R2)), mem_ready held 0 for 3 cycles then 1 → MemRead high 4 cycles, MemtoReg=1, then a one-cycle RegWrite in WB; total 8 cycles; mem_err=0.
3. instr=32'hF8A20008 (std R5,2(R2)), mem_ready never asserted, MEM_TIMEOUT=16 → MemWrite high exactly 16 cycles, then 0; mem_err=1; no pc_en ever; RegWrite never 1.
4. Branch: opcode 16, BO=01100: zero_flag=1 in EXEC → pc_en=1, pc_src=1 at cycle 3. BO=00100 with zero_flag=1 → pc_src=0.
5. instr=32'h00000000 → illegal=1 in TRAP, all enables 0 for 20 cycles; rst pulse low mid-trap clears illegal, returns to FETCH.
6. With UPOWER_PERF_CNT_EN: execute 32'h7E000A14 (add), 32'h70D60000 (andi), 32'h7CD83839 (and) → retired_count=3. rst asserted during the ld MEM state → MemRead drops immediately, count=0.
